// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, states and buffer entry type for the fetch stage
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package fetch_pkg;
  localparam int ADDR_W           = `RISCV_ADDR_WIDTH;
  localparam int WORD_W           = `RISCV_WORD_WIDTH;
  localparam int FETCH_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order prefetch buffer; slot 0 is always the head so outputs come straight from flops
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_entry,
  output fetch_entry_t     o_head,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);
  fetch_entry_t     r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_count_n;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_pop     = i_pop && (r_count != '0);
  assign w_push    = i_push && ((r_count < CNT_W'(DEPTH)) || w_pop);
  assign w_count_n = i_flush ? '0 : r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_wr_idx  = IDX_W'(r_count - CNT_W'(w_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_count <= w_count_n;
      r_valid <= (w_count_n != '0);
      if (!i_flush) begin
        // shift first so a simultaneous push lands behind the surviving entries
        if (w_pop) for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
        if (w_push) r_mem[w_wr_idx] <= i_entry;
      end
    end
  end

  assign o_head  = r_mem[0];
  assign o_valid = r_valid;
  assign o_count = r_count;
endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencing, memory request issue, prefetch buffering and redirect flushing
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int                DEPTH      = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  output logic              instr_valid_o,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] target_addr_i,
  input  logic              target_valid_i
);
  localparam int             CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(FETCH_WORD_BYTES);

  fetch_state_e      r_state, w_state_n;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr, r_pc, r_rsp_pc, w_base;
  logic [CNT_W-1:0]  r_outstanding, r_discard, w_out_n, w_discard_n;
  logic [CNT_W-1:0]  w_fifo_count, w_fifo_count_n;
  logic              w_grant, w_pending, w_resp, w_push, w_pop, w_issue;
  fetch_entry_t      w_push_entry, w_head;

  assign w_grant   = r_req && mem_gnt_i;
  assign w_pending = r_req && !mem_gnt_i;
  // responses with nothing tracked belong to requests issued before a reset
  assign w_resp    = mem_rvalid_i && (r_outstanding != '0);
  assign w_push    = w_resp && (r_discard == '0) && !target_valid_i;
  assign w_pop     = instr_valid_o && instr_req_i && !target_valid_i;
  assign w_base    = target_valid_i ? (target_addr_i & ~ADDR_W'(FETCH_WORD_BYTES - 1)) : r_pc;
  assign w_fifo_count_n = target_valid_i ? '0
                        : w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_issue   = (r_state != BOOT) && (({1'b0, w_out_n} + {1'b0, w_fifo_count_n}) < DEPTH_L);
  assign w_push_entry = '{addr: r_rsp_pc, data: mem_rdata_i};

  always_comb begin
    w_out_n     = r_outstanding + CNT_W'(w_grant) - CNT_W'(w_resp);
    w_discard_n = r_discard;
    if (target_valid_i)
      w_discard_n = w_out_n + CNT_W'(w_pending);
    else if (w_resp && (r_discard != '0))
      w_discard_n = r_discard - CNT_W'(1);
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      BOOT:       w_state_n = RUN;
      RUN, DRAIN: w_state_n = (w_discard_n != '0) ? DRAIN : RUN;
      default:    w_state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_state_n;
  end

  // r_pc is the next address not yet issued; r_rsp_pc is the address of the next kept response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req         <= 1'b0;
      r_addr        <= RESET_ADDR;
      r_pc          <= RESET_ADDR;
      r_rsp_pc      <= RESET_ADDR;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_n;
      r_discard     <= w_discard_n;
      if (target_valid_i)
        r_rsp_pc <= w_base;
      else if (w_push)
        r_rsp_pc <= r_rsp_pc + STEP;
      if (w_pending) begin
        if (target_valid_i) r_pc <= w_base;
      end else begin
        r_req <= w_issue;
        if (w_issue) begin
          r_addr <= w_base;
          r_pc   <= w_base + STEP;
        end else begin
          r_pc   <= w_base;
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (target_valid_i),
    .i_entry (w_push_entry),
    .o_head  (w_head),
    .o_valid (instr_valid_o),
    .o_count (w_fifo_count)
  );

  assign mem_req_o    = r_req;
  assign mem_addr_o   = r_addr;
  assign instr_o      = w_head.data;
  assign instr_addr_o = w_head.addr;
endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - randomized bench for fetch_controller against a stream-level fetch model
module tb_fetch_controller;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_rdata_i;
  logic [31:0] instr_o, instr_addr_o, target_addr_i;
  logic        instr_valid_o, instr_req_i, target_valid_i;

  always #5 clk = ~clk;

  fetch_controller #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .instr_o        (instr_o),
    .instr_addr_o   (instr_addr_o),
    .instr_valid_o  (instr_valid_o),
    .instr_req_i    (instr_req_i),
    .target_addr_i  (target_addr_i),
    .target_valid_i (target_valid_i)
  );

  int total = 0;
  int bad   = 0;
  int delivered = 0;
  int gnt_pct, rv_pct, req_pct, redir_pct;

  // stream-level model: memory in-flight queue, expected request and delivery addresses
  logic [31:0] q_inflight [$];
  logic [31:0] exp_addr, next_req, prev_addr;
  bit          prev_hold, redir_flag, expect_idle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic idle_inputs();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    instr_req_i = 1'b0; target_valid_i = 1'b0; target_addr_i = '0;
  endtask

  task automatic model_reset();
    q_inflight.delete();
    exp_addr = RESET_ADDR; next_req = RESET_ADDR; prev_addr = RESET_ADDR;
    prev_hold = 1'b0; redir_flag = 1'b0; expect_idle = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   mem_req_o,     0);
    check({tag, "_addr"},  mem_addr_o,    RESET_ADDR);
    check({tag, "_valid"}, instr_valid_o, 0);
    check({tag, "_instr"}, instr_o,       0);
    check({tag, "_iaddr"}, instr_addr_o,  0);
  endtask

  task automatic release_and_boot();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); check("boot_e0_req", mem_req_o, 0);
    @(negedge clk); check("boot_e1_req", mem_req_o, 0);
    @(negedge clk); check("boot_e2_req", mem_req_o, 1);
    check("boot_e2_addr", mem_addr_o, RESET_ADDR);
  endtask

  // called at a negedge: check outputs, drive this cycle's inputs, advance the model
  task automatic step(input bit force_tv, input logic [31:0] force_tgt);
    bit          g, rv, rq, tv;
    logic [31:0] tgt;
    if (prev_hold) begin
      check("req_held", mem_req_o, 1);
      check("addr_held", mem_addr_o, prev_addr);
    end else if (mem_req_o) begin
      check("req_addr", mem_addr_o, next_req);
    end
    if (expect_idle) check("flush_valid", instr_valid_o, 0);
    if (instr_valid_o) begin
      check("instr_addr", instr_addr_o, exp_addr);
      check("instr_data", instr_o, mem_word(exp_addr));
    end
    check("inflight_cap", q_inflight.size() <= DEPTH, 1);

    g   = mem_req_o && ($urandom_range(99) < gnt_pct);
    rv  = (q_inflight.size() != 0) && ($urandom_range(99) < rv_pct);
    rq  = $urandom_range(99) < req_pct;
    tv  = force_tv || ($urandom_range(99) < redir_pct);
    tgt = force_tv ? force_tgt : $urandom;

    mem_gnt_i = g; mem_rvalid_i = rv; instr_req_i = rq;
    target_valid_i = tv; target_addr_i = tgt;
    if (rv) mem_rdata_i = mem_word(q_inflight[0]);
    else    mem_rdata_i = $urandom;

    if (rv) void'(q_inflight.pop_front());
    if (g) begin
      q_inflight.push_back(mem_addr_o);
      if (!redir_flag) next_req = mem_addr_o + 32'd4;
      redir_flag = 1'b0;
    end
    if (tv) begin
      next_req   = tgt & ~32'h3;
      redir_flag = mem_req_o && !g;
    end
    prev_hold = mem_req_o && !g;
    prev_addr = mem_addr_o;
    if (tv) begin
      exp_addr    = tgt & ~32'h3;
      expect_idle = 1'b1;
    end else begin
      expect_idle = 1'b0;
      if (instr_valid_o && rq) begin
        exp_addr += 32'd4;
        delivered++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 32'h0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    release_and_boot();

    gnt_pct = 100; rv_pct = 100; req_pct = 100; redir_pct = 0;
    run(40);
    check("progress_seq", delivered > 10, 1);

    req_pct = 0;
    run(12);
    check("stall_req", mem_req_o, 0);
    check("stall_valid", instr_valid_o, 1);
    req_pct = 100;
    run(10);

    rv_pct = 0;
    run(4);
    step(1'b1, 32'h0000_0100);
    rv_pct = 100;
    run(12);

    gnt_pct = 0;
    run(2);
    step(1'b1, 32'h0000_0100);
    run(2);
    gnt_pct = 100;
    run(12);

    step(1'b1, 32'hFFFF_FFF4);
    run(15);

    gnt_pct = 60; rv_pct = 60; req_pct = 70; redir_pct = 5;
    run(3000);
    check("progress_rand", delivered > 300, 1);

    @(posedge clk); #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    idle_inputs();
    model_reset();
    release_and_boot();
    gnt_pct = 100; rv_pct = 100; req_pct = 100; redir_pct = 0;
    run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
